// File: rtl/door_alarm_sequencer.sv
// Door-open alarm sequencer: grace period, intermittent beep, escalation to a
// continuous tone, with acknowledge-driven snooze. All outputs registered.
module door_alarm_sequencer #(
  parameter int GRACE_CYCLES    = 16,
  parameter int BEEP_HALF       = 4,
  parameter int ESCALATE_CYCLES = 64,
  parameter int SNOOZE_CYCLES   = 32,
  parameter int CNT_W           = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       warn_door_open,
  input  logic       ack,
  output logic       buzzer,
  output logic       alarm_led,
  output logic [1:0] alarm_level
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRACE  = 3'd1,
    BEEP   = 3'd2,
    CONT   = 3'd3,
    SNOOZE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] GRACE_LAST  = CNT_W'(GRACE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(BEEP_HALF - 1);
  localparam logic [CNT_W-1:0] ESC_LAST    = CNT_W'(ESCALATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] phase;
  logic [1:0]       holdoff;
  logic             warn;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // The upstream flag is undefined for two cycles after reset; mask it.
  assign warn = warn_door_open && (holdoff == 2'd2);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      phase       <= '0;
      holdoff     <= 2'd0;
      buzzer      <= 1'b0;
      alarm_led   <= 1'b0;
      alarm_level <= 2'd0;
    end else begin
      if (holdoff != 2'd2) holdoff <= holdoff + 2'd1;

      case (state)
        IDLE: begin
          buzzer      <= 1'b0;
          alarm_led   <= 1'b0;
          alarm_level <= 2'd0;
          cnt         <= '0;
          phase       <= '0;
          if (warn) state <= GRACE;
        end

        GRACE: begin
          if (!warn) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == GRACE_LAST) begin
            state       <= BEEP;
            cnt         <= '0;
            phase       <= '0;
            buzzer      <= 1'b1;
            alarm_led   <= 1'b1;
            alarm_level <= 2'd1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        BEEP: begin
          if (!warn) begin
            state       <= IDLE;
            cnt         <= '0;
            phase       <= '0;
            buzzer      <= 1'b0;
            alarm_led   <= 1'b0;
            alarm_level <= 2'd0;
          end else if (ack) begin
            state       <= SNOOZE;
            cnt         <= '0;
            buzzer      <= 1'b0;
            alarm_led   <= 1'b1;
            alarm_level <= 2'd3;
          end else if (cnt == ESC_LAST) begin
            state       <= CONT;
            buzzer      <= 1'b1;
            alarm_led   <= 1'b1;
            alarm_level <= 2'd2;
          end else begin
            cnt         <= sat_inc(cnt);
            alarm_led   <= 1'b1;
            alarm_level <= 2'd1;
            // Buzzer cadence runs off its own phase so escalation timing is untouched.
            if (phase == HALF_LAST) begin
              phase  <= '0;
              buzzer <= ~buzzer;
            end else begin
              phase <= sat_inc(phase);
            end
          end
        end

        CONT: begin
          if (!warn) begin
            state       <= IDLE;
            cnt         <= '0;
            phase       <= '0;
            buzzer      <= 1'b0;
            alarm_led   <= 1'b0;
            alarm_level <= 2'd0;
          end else if (ack) begin
            state       <= SNOOZE;
            cnt         <= '0;
            buzzer      <= 1'b0;
            alarm_led   <= 1'b1;
            alarm_level <= 2'd3;
          end else begin
            buzzer      <= 1'b1;
            alarm_led   <= 1'b1;
            alarm_level <= 2'd2;
          end
        end

        SNOOZE: begin
          // ack is deliberately not looked at here: holding it cannot extend the snooze.
          if (!warn) begin
            state       <= IDLE;
            cnt         <= '0;
            phase       <= '0;
            buzzer      <= 1'b0;
            alarm_led   <= 1'b0;
            alarm_level <= 2'd0;
          end else if (cnt == SNOOZE_LAST) begin
            state       <= BEEP;
            cnt         <= '0;
            phase       <= '0;
            buzzer      <= 1'b1;
            alarm_led   <= 1'b1;
            alarm_level <= 2'd1;
          end else begin
            cnt         <= sat_inc(cnt);
            buzzer      <= 1'b0;
            alarm_led   <= 1'b1;
            alarm_level <= 2'd3;
          end
        end

        default: begin
          state       <= IDLE;
          cnt         <= '0;
          phase       <= '0;
          buzzer      <= 1'b0;
          alarm_led   <= 1'b0;
          alarm_level <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_door_alarm_sequencer.sv
// Directed bench for door_alarm_sequencer; outputs checked as {buzzer, alarm_led, alarm_level}.
module tb_door_alarm_sequencer;

  logic       clock;
  logic       reset;
  logic       warn_door_open;
  logic       ack;
  logic       buzzer;
  logic       alarm_led;
  logic [1:0] alarm_level;
  logic [3:0] obs;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] OFF      = 4'b0000;
  localparam logic [3:0] BEEP_ON  = 4'b1101;
  localparam logic [3:0] BEEP_OFF = 4'b0101;
  localparam logic [3:0] CONT_ON  = 4'b1110;
  localparam logic [3:0] SNZ      = 4'b0111;

  door_alarm_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .warn_door_open (warn_door_open),
    .ack            (ack),
    .buzzer         (buzzer),
    .alarm_led      (alarm_led),
    .alarm_level    (alarm_level)
  );

  assign obs = {buzzer, alarm_led, alarm_level};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    warn_door_open = 1'b0;
    ack = 1'b0;
    step();
    step();
    chk("reset", obs, OFF);
    reset = 1'b0;

    // Long warning, no ack: grace, beep cadence, escalation
    step();
    step();
    warn_door_open = 1'b1;
    step();
    chk("t1_grace_entry", obs, OFF);
    repeat (15) step();
    chk("t1_grace_end", obs, OFF);
    step();
    chk("t1_first_beep", obs, BEEP_ON);
    repeat (3) step();
    chk("t1_beep_hi", obs, BEEP_ON);
    step();
    chk("t1_beep_lo", obs, BEEP_OFF);
    repeat (4) step();
    chk("t1_beep_hi2", obs, BEEP_ON);
    repeat (55) step();
    chk("t1_pre_escalate", obs, BEEP_OFF);
    step();
    chk("t1_continuous", obs, CONT_ON);
    repeat (20) step();
    chk("t1_cont_hold", obs, CONT_ON);
    ack = 1'b1;
    step();
    chk("t1_cont_ack", obs, SNZ);
    ack = 1'b0;
    warn_door_open = 1'b0;
    step();
    chk("t1_snooze_warn_drop", obs, OFF);

    // Short warning never reaches the alarm; next one gets a full grace
    warn_door_open = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_short_warn", obs, OFF);
    end
    warn_door_open = 1'b0;
    step();
    chk("t2_idle", obs, OFF);
    warn_door_open = 1'b1;
    repeat (16) step();
    chk("t2_regrace_end", obs, OFF);
    step();
    chk("t2_beep", obs, BEEP_ON);

    // One-cycle ack in BEEP: 32-cycle snooze then beeping resumes
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t3_snooze", obs, SNZ);
    repeat (31) step();
    chk("t3_snooze_end", obs, SNZ);
    step();
    chk("t3_resume", obs, BEEP_ON);

    // Escalate again, then ack together with warn falling
    repeat (63) step();
    chk("t4_pre_escalate", obs, BEEP_OFF);
    step();
    chk("t4_continuous", obs, CONT_ON);
    ack = 1'b1;
    warn_door_open = 1'b0;
    step();
    chk("t4_ack_and_drop", obs, OFF);
    ack = 1'b0;

    // Warning high through reset and holdoff
    reset = 1'b1;
    warn_door_open = 1'b1;
    step();
    step();
    chk("t5_reset", obs, OFF);
    reset = 1'b0;
    repeat (18) step();
    chk("t5_holdoff_grace", obs, OFF);
    step();
    chk("t5_first_beep", obs, BEEP_ON);

    // One-cycle reset in CONTINUOUS restarts the whole sequence
    repeat (64) step();
    chk("t6_continuous", obs, CONT_ON);
    reset = 1'b1;
    step();
    chk("t6_reset", obs, OFF);
    reset = 1'b0;
    repeat (18) step();
    chk("t6_holdoff_grace", obs, OFF);
    step();
    chk("t6_first_beep", obs, BEEP_ON);

    // ack held through a snooze does not extend it
    ack = 1'b1;
    step();
    chk("t7_snooze", obs, SNZ);
    repeat (31) step();
    chk("t7_snooze_end", obs, SNZ);
    step();
    chk("t7_resume_held_ack", obs, BEEP_ON);
    ack = 1'b0;
    warn_door_open = 1'b0;
    step();
    chk("t7_idle", obs, OFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
